// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: button, running-time and set-side signals of the
// time-setting controller. btn_dec exists only when TIME_SET_DEC_EN is defined.
// master = the controller, slave = the surrounding debouncers/time counter.
interface time_set_ctrl_if;
    logic       clk_1hz_tick;
    logic       btn_mode;
    logic       btn_inc;
`ifdef TIME_SET_DEC_EN
    logic       btn_dec;
`endif
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       set_en;
    logic       set_load;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic [1:0] edit_field;

    modport master (
`ifdef TIME_SET_DEC_EN
        input  btn_dec,
`endif
        input  clk_1hz_tick, btn_mode, btn_inc, cur_hh, cur_mm, cur_ss,
        output set_en, set_load, set_hh, set_mm, set_ss, edit_field
    );

    modport slave (
`ifdef TIME_SET_DEC_EN
        output btn_dec,
`endif
        output clk_1hz_tick, btn_mode, btn_inc, cur_hh, cur_mm, cur_ss,
        input  set_en, set_load, set_hh, set_mm, set_ss, edit_field
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: captures the running BCD time, lets the user step through
// hours/minutes/seconds with button pulses and writes the edited time back
// with a one-cycle set_load strobe. An idle edit is abandoned after TIMEOUT_S
// seconds without an accepted button (0 disables the timeout).
// Optional feature macro: TIME_SET_DEC_EN adds btn_dec and decrement logic.
module time_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    time_set_ctrl_if.master  bus
);

    localparam int TW_RAW = $clog2(TIMEOUT_S + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam bit TO_EN  = (TIMEOUT_S != 0);
    // Count value at which the next 1 Hz tick expires the edit.
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_S == 0) ? 0 : TIMEOUT_S - 1);

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_HH = 3'd1,
        EDIT_MM = 3'd2,
        EDIT_SS = 3'd3,
        LOAD    = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic          in_edit;
    logic          step_up;
`ifdef TIME_SET_DEC_EN
    logic          step_dn;
`endif
    logic          edit_step;
    logic          expire;

    // BCD +1 with wrap at max; anything malformed or out of range snaps to 00.
    // Valid BCD orders the same as its hex value, so a plain compare works.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (t > 4'd9 || u > 4'd9 || v >= max) begin
            return 8'h00;
        end
        if (u == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

`ifdef TIME_SET_DEC_EN
    // BCD -1 with wrap from 00 to max; malformed or out-of-range snaps to 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (t > 4'd9 || u > 4'd9 || v > max) begin
            return 8'h00;
        end
        if (v == 8'h00) begin
            return max;
        end
        if (u == 4'd0) begin
            return {t - 4'd1, 4'd9};
        end
        return {t, u - 4'd1};
    endfunction
`endif

    // Decode accepted field steps and the expiring timeout tick.
    always_comb begin
        in_edit = (state == EDIT_HH) || (state == EDIT_MM) || (state == EDIT_SS);
`ifdef TIME_SET_DEC_EN
        // Simultaneous inc and dec cancel each other.
        step_up   = bus.btn_inc & ~bus.btn_dec;
        step_dn   = bus.btn_dec & ~bus.btn_inc;
        edit_step = step_up | step_dn;
`else
        step_up   = bus.btn_inc;
        edit_step = step_up;
`endif
        expire = TO_EN && in_edit && bus.clk_1hz_tick && (to_cnt == TO_LAST);
    end

    // Edit FSM with registered outputs, field registers and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            to_cnt         <= '0;
            bus.set_en     <= 1'b0;
            bus.set_load   <= 1'b0;
            bus.edit_field <= 2'd0;
            bus.set_hh     <= 8'h00;
            bus.set_mm     <= 8'h00;
            bus.set_ss     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    // A same-cycle 1 Hz tick is lost: the commit restores this capture.
                    if (bus.btn_mode) begin
                        state          <= EDIT_HH;
                        to_cnt         <= '0;
                        bus.set_en     <= 1'b1;
                        bus.edit_field <= 2'd1;
                        bus.set_hh     <= bus.cur_hh;
                        bus.set_mm     <= bus.cur_mm;
                        bus.set_ss     <= bus.cur_ss;
                    end
                end

                EDIT_HH, EDIT_MM, EDIT_SS: begin
                    if (bus.btn_mode) begin
                        // Mode outranks inc/dec in the same cycle.
                        to_cnt <= '0;
                        case (state)
                            EDIT_HH: begin
                                state          <= EDIT_MM;
                                bus.edit_field <= 2'd2;
                            end
                            EDIT_MM: begin
                                state          <= EDIT_SS;
                                bus.edit_field <= 2'd3;
                            end
                            default: begin
                                state          <= LOAD;
                                bus.edit_field <= 2'd0;
                                bus.set_load   <= 1'b1;
                            end
                        endcase
                    end else if (edit_step) begin
                        // A button beats an expiring tick in the same cycle.
                        to_cnt <= '0;
                        case (state)
                            EDIT_HH: begin
`ifdef TIME_SET_DEC_EN
                                bus.set_hh <= step_up ? bcd_inc(bus.set_hh, HH_MAX)
                                                      : bcd_dec(bus.set_hh, HH_MAX);
`else
                                bus.set_hh <= bcd_inc(bus.set_hh, HH_MAX);
`endif
                            end
                            EDIT_MM: begin
`ifdef TIME_SET_DEC_EN
                                bus.set_mm <= step_up ? bcd_inc(bus.set_mm, MS_MAX)
                                                      : bcd_dec(bus.set_mm, MS_MAX);
`else
                                bus.set_mm <= bcd_inc(bus.set_mm, MS_MAX);
`endif
                            end
                            default: begin
`ifdef TIME_SET_DEC_EN
                                bus.set_ss <= step_up ? bcd_inc(bus.set_ss, MS_MAX)
                                                      : bcd_dec(bus.set_ss, MS_MAX);
`else
                                bus.set_ss <= bcd_inc(bus.set_ss, MS_MAX);
`endif
                            end
                        endcase
                    end else if (expire) begin
                        // Abandon the edit without loading; the counter resumes.
                        state          <= IDLE;
                        to_cnt         <= '0;
                        bus.set_en     <= 1'b0;
                        bus.edit_field <= 2'd0;
                    end else if (TO_EN && bus.clk_1hz_tick) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                LOAD: begin
                    state        <= IDLE;
                    bus.set_en   <= 1'b0;
                    bus.set_load <= 1'b0;
                end

                default: begin
                    state          <= IDLE;
                    to_cnt         <= '0;
                    bus.set_en     <= 1'b0;
                    bus.set_load   <= 1'b0;
                    bus.edit_field <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed scenarios plus randomized traffic for
// time_set_ctrl, checked against a behavioural edit model held here.
module tb_time_set_ctrl;

    localparam int TB_TIMEOUT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    time_set_ctrl_if bus();

    time_set_ctrl #(.TIMEOUT_S(TB_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1..3 editing hh/mm/ss, 4 load.
    int         m_phase;
    int         m_to;
    logic [7:0] m_set [3];

    logic [27:0] obs;
    assign obs = {bus.set_en, bus.set_load, bus.edit_field, bus.set_hh, bus.set_mm, bus.set_ss};

    function automatic int bcd_val(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Step a field by +1/-1 modulo (maxv+1); invalid values go to 00.
    function automatic logic [7:0] model_adj(input logic [7:0] b, input int maxv, input int delta);
        int v;
        v = bcd_val(b);
        if (v < 0 || v > maxv) return 8'h00;
        return to_bcd((v + delta + maxv + 1) % (maxv + 1));
    endfunction

    function automatic logic [27:0] model_out();
        logic [1:0] f;
        f = (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase) : 2'd0;
        return {(m_phase != 0), (m_phase == 4), f, m_set[0], m_set[1], m_set[2]};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_to    = 0;
        for (int i = 0; i < 3; i++) m_set[i] = 8'h00;
    endtask

    task automatic model_update(input logic mode, input logic inc, input logic dec, input logic tick);
        logic up;
        logic dn;
        int   maxv;
`ifdef TIME_SET_DEC_EN
        up = inc && !dec;
        dn = dec && !inc;
`else
        up = inc;
        dn = 1'b0;
`endif
        if (m_phase == 0) begin
            if (mode) begin
                m_set[0] = bus.cur_hh;
                m_set[1] = bus.cur_mm;
                m_set[2] = bus.cur_ss;
                m_phase  = 1;
                m_to     = 0;
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else begin
            maxv = (m_phase == 1) ? 23 : 59;
            if (mode) begin
                m_phase = m_phase + 1;
                m_to    = 0;
            end else if (up || dn) begin
                m_set[m_phase-1] = model_adj(m_set[m_phase-1], maxv, up ? 1 : -1);
                m_to = 0;
            end else if (tick && TB_TIMEOUT != 0) begin
                m_to = m_to + 1;
                if (m_to >= TB_TIMEOUT) begin
                    m_phase = 0;
                    m_to    = 0;
                end
            end
        end
    endtask

    // Apply one cycle of button/tick pulses and advance the model at the edge.
    task automatic step(input logic mode, input logic inc, input logic dec, input logic tick);
        bus.btn_mode     = mode;
        bus.btn_inc      = inc;
`ifdef TIME_SET_DEC_EN
        bus.btn_dec      = dec;
`endif
        bus.clk_1hz_tick = tick;
        @(posedge clk);
        model_update(mode, inc, dec, tick);
        #1;
        bus.btn_mode     = 1'b0;
        bus.btn_inc      = 1'b0;
`ifdef TIME_SET_DEC_EN
        bus.btn_dec      = 1'b0;
`endif
        bus.clk_1hz_tick = 1'b0;
    endtask

    task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        bus.cur_hh = hh;
        bus.cur_mm = mm;
        bus.cur_ss = ss;
    endtask

    task automatic test_reset();
        logic [27:0] exp;
        model_reset();
        #12;
        exp = 28'h0;
        checks++; if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_cur(8'h11, 8'h22, 8'h33);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (obs !== exp) begin failures++; $display("FAIL idle_ignores_inc got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_basic_commit();
        logic [27:0] exp;
        set_cur(8'h12, 8'h34, 8'h56);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h123456};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_capture got=%h exp=%h", obs, exp); end
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h153456};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_hh_inc3 got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h153556};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_mm_inc got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd3, 24'h153556};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_ss_field got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp = {1'b1, 1'b1, 2'd0, 24'h153556};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_load got=%h exp=%h", obs, exp); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        exp = {1'b0, 1'b0, 2'd0, 24'h153556};
        checks++; if (obs !== exp) begin failures++; $display("FAIL basic_back_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        logic [27:0] exp;
        set_cur(8'h23, 8'h59, 8'h59);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h005959};
        checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_hh got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h000059};
        checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_mm got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd3, 24'h000000};
        checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_ss got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        set_cur(8'h09, 8'h09, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h100900};
        checks++; if (obs !== exp) begin failures++; $display("FAIL carry_hh_09 got=%h exp=%h", obs, exp); end
        repeat (9) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h200900};
        checks++; if (obs !== exp) begin failures++; $display("FAIL carry_hh_19 got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h201000};
        checks++; if (obs !== exp) begin failures++; $display("FAIL carry_mm_09 got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        exp = {1'b0, 1'b0, 2'd0, 24'h201000};
        checks++; if (obs !== exp) begin failures++; $display("FAIL carry_commit_idle got=%h exp=%h", obs, exp); end
    endtask

`ifdef TIME_SET_DEC_EN
    task automatic test_dec();
        logic [27:0] exp;
        set_cur(8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 1'b0, 2'd1, 24'h230000};
        checks++; if (obs !== exp) begin failures++; $display("FAIL dec_hh got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h235900};
        checks++; if (obs !== exp) begin failures++; $display("FAIL dec_mm got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 1'b0, 2'd3, 24'h235959};
        checks++; if (obs !== exp) begin failures++; $display("FAIL dec_ss got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        set_cur(8'h00, 8'h10, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h000900};
        checks++; if (obs !== exp) begin failures++; $display("FAIL dec_mm_10 got=%h exp=%h", obs, exp); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (obs !== exp) begin failures++; $display("FAIL inc_dec_cancel got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_collision();
        logic [27:0] exp;
        set_cur(8'h07, 8'h20, 8'h30);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h072030};
        checks++; if (obs !== exp) begin failures++; $display("FAIL mode_over_inc got=%h exp=%h", obs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {1'b0, 1'b0, 2'd0, 24'h072030};
        checks++; if (obs !== exp) begin failures++; $display("FAIL load_ignores_btn got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_timeout();
        logic [27:0] exp;
        set_cur(8'h01, 8'h02, 8'h03);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = {1'b1, 1'b0, 2'd1, 24'h010203};
        checks++; if (obs !== exp) begin failures++; $display("FAIL timeout_not_yet got=%h exp=%h", obs, exp); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = {1'b0, 1'b0, 2'd0, 24'h010203};
        checks++; if (obs !== exp) begin failures++; $display("FAIL timeout_expire got=%h exp=%h", obs, exp); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (bus.set_load !== 1'b0) begin failures++; $display("FAIL timeout_no_load got=%b exp=0", bus.set_load); end
        end

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        exp = {1'b1, 1'b0, 2'd1, 24'h020203};
        checks++; if (obs !== exp) begin failures++; $display("FAIL timeout_btn_wins got=%h exp=%h", obs, exp); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs !== exp) begin failures++; $display("FAIL timeout_restarted got=%h exp=%h", obs, exp); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = {1'b0, 1'b0, 2'd0, 24'h020203};
        checks++; if (obs !== exp) begin failures++; $display("FAIL timeout_second got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        logic [27:0] exp;
        set_cur(8'h04, 8'h05, 8'h06);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 2'd2, 24'h040506};
        checks++; if (obs !== exp) begin failures++; $display("FAIL pre_reset_edit_mm got=%h exp=%h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp = 28'h0;
        checks++; if (obs !== exp) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp); end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            bus.btn_mode = 1'b1;
            @(posedge clk); #1;
            bus.btn_mode = 1'b0;
            checks++; if (obs !== exp) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs !== exp) begin failures++; $display("FAIL reset_release_no_load got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_random();
        logic [27:0] exp;
        logic mode, inc, dec, tick;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    set_cur(8'($urandom), 8'($urandom), 8'($urandom));
                else
                    set_cur(to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                            to_bcd(int'($urandom_range(0, 59))));
            end
            mode = ($urandom_range(0, 9) == 0);
            inc  = ($urandom_range(0, 3) == 0);
            dec  = ($urandom_range(0, 3) == 0);
            tick = ($urandom_range(0, 4) == 0);
            step(mode, inc, dec, tick);
            exp = model_out();
            checks++; if (obs !== exp) begin failures++; $display("FAIL random_cycle_%0d got=%h exp=%h", i, obs, exp); end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.btn_mode     = 1'b0;
        bus.btn_inc      = 1'b0;
`ifdef TIME_SET_DEC_EN
        bus.btn_dec      = 1'b0;
`endif
        bus.clk_1hz_tick = 1'b0;
        set_cur(8'h00, 8'h00, 8'h00);
        test_reset();
        test_basic_commit();
        test_wrap();
`ifdef TIME_SET_DEC_EN
        test_dec();
`endif
        test_collision();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
